inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 18 +
 rtl/inst_loader_if.sv | 34 +++
 rtl/inst_loader.sv | 146 ++++++++++++++
 tb/tb_inst_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction RAM it fills.
package inst_loader_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RAM_DEPTH = 256;
    localparam int unsigned CNT_W     = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_HI = 3'd1,
        GET_LO = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface inst_loader_if #(
    parameter int unsigned ADDR_W = inst_loader_pkg::ADDR_W,
    parameter int unsigned DATA_W = inst_loader_pkg::DATA_W
);

    logic [DATA_W/2-1:0] byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic [DATA_W-1:0]   ram_din;
    logic [ADDR_W-1:0]   ram_add;
    logic                ram_we;

    // Loader side: consumes bytes, drives the RAM write port.
    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output ram_din,
        output ram_add,
        output ram_we
    );

    // Byte source / instruction RAM side.
    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  ram_din,
        input  ram_add,
        input  ram_we
    );

endinterface

// File: rtl/inst_loader.sv
// Assembles big-endian byte pairs into instruction words and writes them
// to consecutive instruction RAM addresses, holding the CPU until done.
module inst_loader #(
    parameter int unsigned ADDR_W = inst_loader_pkg::ADDR_W,
    parameter int unsigned DATA_W = inst_loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    inst_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    import inst_loader_pkg::*;

    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    count_q, count_d;
    logic [HALF_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic [ADDR_W-1:0]   ram_add_q, ram_add_d;
    logic                ram_we_q, ram_we_d;
    logic                byte_ready_q, byte_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;
    logic                xfer_c;
    logic                count_ok_c;
    logic [PTR_W-1:0]    ptr_inc_c;

    assign xfer_c     = bus.byte_valid & byte_ready_q;
    assign count_ok_c = (num_words != '0) && (num_words <= PTR_W'(DEPTH));
    assign ptr_inc_c  = ptr_q + PTR_W'(1);

    // State and registered-output update; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            hi_q         <= '0;
            ram_din_q    <= '0;
            ram_add_q    <= '0;
            ram_we_q     <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            hold_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            ram_din_q    <= ram_din_d;
            ram_add_q    <= ram_add_d;
            ram_we_q     <= ram_we_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            hold_q       <= hold_d;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        hi_d      = hi_q;
        ram_din_d = ram_din_q;
        ram_add_d = ram_add_q;
        done_d    = done_q;
        err_d     = err_q;
        hold_d    = hold_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    done_d = 1'b0;
                    if (count_ok_c) begin
                        state_d = GET_HI;
                        ptr_d   = '0;
                        count_d = num_words;
                        err_d   = 1'b0;
                        hold_d  = 1'b1;
                    end else begin
                        // Rejected request leaves program memory as it was.
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            GET_HI: begin
                if (xfer_c) begin
                    hi_d    = bus.byte_in;
                    state_d = GET_LO;
                end
            end
            GET_LO: begin
                if (xfer_c) begin
                    ram_din_d = {hi_q, bus.byte_in};
                    ram_add_d = ptr_q[ADDR_W-1:0];
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // Pointer is one bit wider than the address so a full-depth
                // load terminates on count instead of wrapping to zero.
                ptr_d = ptr_inc_c;
                if (ptr_inc_c == count_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = GET_HI;
                end
            end
            default: state_d = IDLE;
        endcase

        ram_we_d     = (state_d == WRITE);
        byte_ready_d = (state_d == GET_HI) || (state_d == GET_LO);
        busy_d       = (state_d == GET_HI) || (state_d == GET_LO) || (state_d == WRITE);
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.ram_add    = ram_add_q;
    assign bus.ram_we     = ram_we_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cpu_hold       = hold_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for the instruction loader.
module tb_inst_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] num_words = '0;
    logic       busy, done, err, cpu_hold;

    inst_loader_if bus ();

    inst_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Expected status as seen by the CPU side.
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    bit m_hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.ram_we !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got we=%b addr 0x%0h data 0x%0h expected no write (cycle %0d)",
                         bus.ram_we, bus.ram_add, bus.ram_din, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_addr", 32'(bus.ram_add), 32'(e.addr));
                chk("write_data", 32'(bus.ram_din), 32'(e.data));
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, "_busy"},       32'(busy),           32'(0));
        chk({tag, "_done"},       32'(done),           32'(m_done));
        chk({tag, "_err"},        32'(err),            32'(m_err));
        chk({tag, "_cpu_hold"},   32'(cpu_hold),       32'(m_hold));
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(0));
    endtask

    task automatic check_reset(input string tag);
        m_done = 1'b0;
        m_err  = 1'b0;
        m_hold = 1'b1;
        check_status(tag);
        chk({tag, "_ram_we"},  32'(bus.ram_we),  32'(0));
        chk({tag, "_ram_din"}, 32'(bus.ram_din), 32'(0));
        chk({tag, "_ram_add"}, 32'(bus.ram_add), 32'(0));
    endtask

    task automatic do_start(input int n);
        bit legal;
        legal = (n >= 1) && (n <= 256);
        @(negedge clk);
        start = 1'b1;
        num_words = 9'(n);
        @(negedge clk);
        start = 1'b0;
        if (legal) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            m_hold = 1'b1;
            chk("start_busy",       32'(busy),           32'(1));
            chk("start_byte_ready", 32'(bus.byte_ready), 32'(1));
            chk("start_done",       32'(done),           32'(0));
            chk("start_err",        32'(err),            32'(0));
            chk("start_cpu_hold",   32'(cpu_hold),       32'(1));
        end else begin
            m_done = 1'b0;
            m_err  = 1'b1;
            check_status("reject");
        end
    endtask

    // Offers one byte after `gap` idle cycles; a low byte queues its write,
    // due the cycle after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                             input logic [15:0] data, input logic [7:0] addr);
        int waited = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
        end
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        while (bus.byte_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got byte_ready=%b expected 1 within 64 cycles", bus.byte_ready);
            bus.byte_valid = 1'b0;
        end else if (push) begin
            exp_t e;
            e.addr = addr;
            e.data = data;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk({tag, "_pending_writes"}, 32'(sb.size()), 32'(0));
    endtask

    // Full load: mode 0 random bytes, 1 fixed bytes from `fixed`, 2 byte index k.
    task automatic load(input int n, input int mode, input int gap_max, input bit mid_start,
                        input logic [31:0] fixed, input int gap_lo);
        logic [7:0] hi, lo;
        do_start(n);
        for (int i = 0; i < n; i++) begin
            if (mode == 2) begin
                hi = 8'(2 * i);
                lo = 8'(2 * i + 1);
            end else if (mode == 1) begin
                hi = (i == 0) ? fixed[31:24] : fixed[15:8];
                lo = (i == 0) ? fixed[23:16] : fixed[7:0];
            end else begin
                hi = 8'($urandom);
                lo = 8'($urandom);
            end
            send_byte(hi, $urandom_range(0, gap_max), 1'b0, 16'h0, 8'h0);
            if (mid_start && i == 0) begin
                @(negedge clk);
                bus.byte_valid = 1'b0;
                start = 1'b1;
                num_words = 9'd5;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(lo, (gap_lo >= 0) ? gap_lo : $urandom_range(0, gap_max), 1'b1, {hi, lo}, 8'(i));
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        wait_drain("load");
        m_done = 1'b1;
        m_hold = 1'b0;
        check_status("load_end");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Illegal counts straight after reset: no writes, CPU stays held.
        do_start(0);
        do_start(257);
        repeat (3) @(negedge clk);
        check_status("illegal_idle");

        // Two-word load with back-to-back bytes.
        load(2, 1, 0, 1'b0, 32'h1234_ABCD, -1);

        // Single word with the low byte held off for five cycles.
        load(1, 1, 0, 1'b0, 32'h8001_0000, 5);

        // Random sizes, data and gaps.
        for (int r = 0; r < 6; r++) load($urandom_range(1, 20), 0, 2, 1'b0, 32'h0, -1);

        // Start pulsed while waiting for the low byte is ignored.
        load(2, 0, 1, 1'b1, 32'h0, -1);

        // Full depth: byte k carries value k.
        load(256, 2, 0, 1'b0, 32'h0, -1);

        // Bytes offered in DONE are not taken.
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_byte_ready", 32'(bus.byte_ready), 32'(0));
        end
        bus.byte_valid = 1'b0;

        // Rejected start after a good load keeps the CPU released.
        do_start(300);
        repeat (2) @(negedge clk);
        check_status("illegal_after_done");

        // Reset in the middle of word 3.
        do_start(5);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] hi, lo;
            hi = 8'($urandom);
            lo = 8'($urandom);
            send_byte(hi, 0, 1'b0, 16'h0, 8'h0);
            send_byte(lo, 0, 1'b1, {hi, lo}, 8'(i));
        end
        send_byte(8'hEE, 0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pending_writes", 32'(sb.size()), 32'(0));
        check_reset("mid_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_status("after_reset");
        load(1, 0, 1, 1'b0, 32'h0, -1);

        repeat (5) @(negedge clk);
        chk("final_pending_writes", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
